ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter. Inhibits the bus,
//            issues a request-to-send, then shifts out one byte LSB first
//            with odd parity and a stop bit on device-generated clock
//            falling edges. It then samples the device ACK and waits for
//            the bus to go idle before it reports the result.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   INHIBIT_CLK  clk cycles ps2_clk is held low before the request
//   TIMEOUT_CLK  max clk cycles from request entry to transfer completion
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   tx_data[7:0] command byte to send
//   tx_stb       start strobe, honoured only while idle
//   ps2_clk_i    PS/2 clock line as read back from the pin
//   ps2_data_i   PS/2 data line as read back from the pin
//   ps2_clk_oe   1 = pull ps2_clk low
//   ps2_data_oe  1 = pull ps2_data low
//   busy         high whenever a transfer is in progress
//   done         one-cycle pulse on device ACK
//   err          one-cycle pulse on NACK or timeout
// Configuration macro
//   PS2_HOST_TX_RETRY_EN  when defined, NACK/timeout retries the latched
//                         byte up to 2 times before err is reported
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CLK = 400,
  parameter int TIMEOUT_CLK = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_stb,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Counter widths sized to hold the terminal count (value - 1).
  localparam int INH_W = (INHIBIT_CLK > 1) ? $clog2(INHIBIT_CLK) : 1;
  localparam int TMO_W = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK) : 1;

  localparam logic [INH_W-1:0] c_inh_last = INH_W'(INHIBIT_CLK - 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CLK - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_BITS    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           state_q,    state_d;
  logic [7:0]       shift_q,    shift_d;
  logic             parity_q,   parity_d;
  logic [3:0]       bit_cnt_q,  bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic             ack_q,      ack_d;
  logic             clk_oe_q,   clk_oe_d;
  logic             data_oe_q,  data_oe_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0]       retry_cnt_q, retry_cnt_d;
`endif

  // Two-flop synchronisers plus a third clock stage that remembers the
  // previous synchronised level for falling-edge detection. They reset to
  // 1 because an idle PS/2 bus floats high.
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic data_s1_q, data_s2_q;

  logic w_fall;
  logic w_tmo_hit;
  logic w_fail;

  assign w_fall    = clk_s3_q & ~clk_s2_q;
  assign w_tmo_hit = (tmo_cnt_q == c_tmo_last);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_fail    = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_stb) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          bit_cnt_d = 4'd0;
          tmo_cnt_d = '0;
          inh_cnt_d = '0;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_cnt_d = 2'd0;
`endif
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      // Clock edges seen here come from our own inhibit (or from device
      // traffic) and are deliberately ignored.
      S_INHIBIT: begin
        if (inh_cnt_q == c_inh_last) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;   // start bit
          tmo_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        state_d   = S_BITS;
      end

      S_BITS: begin
        if (w_tmo_hit) begin
          w_fail = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (w_fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_d = ~shift_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;   // stop bit: release data
              state_d   = S_ACK;
            end
          end
        end
      end

      S_ACK: begin
        if (w_tmo_hit) begin
          w_fail = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (w_fall) begin
            ack_d   = ~data_s2_q;   // device pulls data low to ACK
            state_d = S_RELEASE;
          end
        end
      end

      S_RELEASE: begin
        if (w_tmo_hit) begin
          w_fail = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (clk_s2_q && data_s2_q) begin
            if (ack_q) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              w_fail = 1'b1;
            end
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Common failure handling for NACK and timeout: always free the bus,
    // then either retry the latched byte or report the error.
    if (w_fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_cnt_q != 2'd2) begin
        retry_cnt_d = retry_cnt_q + 1'b1;
        bit_cnt_d   = 4'd0;
        inh_cnt_d   = '0;
        clk_oe_d    = 1'b1;
        busy_d      = 1'b1;
        state_d     = S_INHIBIT;
      end else begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
`else
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = S_IDLE;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers; reset releases both lines asynchronously.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt_q <= 2'd0;
`endif
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      ack_q     <= ack_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Directed self-checking bench for ps2_host_tx with a simple
//            open-collector PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 400;
  localparam int TMO = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Wired-AND bus: either side can pull a line low.
  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CLK (INH),
    .TIMEOUT_CLK (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_stb      (tx_stb),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Pulse counters and inhibit-phase length monitor.
  int done_cnt   = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int inh_run    = 0;
  int last_inh   = 0;
  int inh_phases = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe === 1'b1) begin
      inh_run <= inh_run + 1;
    end else if (inh_run != 0) begin
      last_inh   <= inh_run;
      inh_phases <= inh_phases + 1;
      inh_run    <= 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_stb  = 1'b1;
    @(negedge clk);
    tx_stb  = 1'b0;
  endtask

  // Device model: waits for the request-to-send, then generates n_edges
  // clock pulses, sampling host data in each low phase. On pulse 11 it
  // drives ACK (data low) unless nack is set.
  task automatic device_xfer(input int n_edges, input bit nack,
                             output logic [7:0] rx, output logic rx_par,
                             output logic rx_stop, output bit to);
    int n;
    to = 1'b0; rx = 8'h00; rx_par = 1'b0; rx_stop = 1'b0; n = 0;
    @(negedge clk);
    while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0 && ps2_clk_oe === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      to = 1'b1;
      return;
    end
    repeat (50) @(negedge clk);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && !nack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      if (i <= 8)       rx[i-1] = ps2_data_i;
      else if (i == 9)  rx_par  = ps2_data_i;
      else if (i == 10) rx_stop = ps2_data_i;
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic test_reset;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_ack_f4;
    logic [7:0] rx; logic par, stp; bit to; int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    total++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin bad++; $display("FAIL f4_start busy=%b clk_oe=%b exp=1,1", busy, ps2_clk_oe); end
    device_xfer(11, 1'b0, rx, par, stp, to);
    total++; if (to) begin bad++; $display("FAIL f4_request got=none exp=request"); end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (last_inh != INH) begin bad++; $display("FAIL f4_inhibit_len got=%0d exp=%0d", last_inh, INH); end
    total++; if (rx !== 8'hF4) begin bad++; $display("FAIL f4_byte got=%h exp=f4", rx); end
    total++; if (par !== 1'b0) begin bad++; $display("FAIL f4_parity got=%b exp=0", par); end
    total++; if (stp !== 1'b1) begin bad++; $display("FAIL f4_stop got=%b exp=1", stp); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL f4_done got=%0d exp=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL f4_err got=%0d exp=0", err_cnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL f4_busy_after got=%b exp=0", busy); end
  endtask

`ifndef PS2_HOST_TX_RETRY_EN
  task automatic test_nack_ff;
    logic [7:0] rx; logic par, stp; bit to; int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    device_xfer(11, 1'b1, rx, par, stp, to);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (rx !== 8'hFF) begin bad++; $display("FAIL ff_byte got=%h exp=ff", rx); end
    total++; if (par !== 1'b1) begin bad++; $display("FAIL ff_parity got=%b exp=1", par); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL ff_err got=%0d exp=1", err_cnt - e0); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL ff_done got=%0d exp=0", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_timeout;
    int n, cnt, e0;
    e0 = err_cnt;
    send(8'h55);
    n = 0;
    while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && n < 1000) begin @(negedge clk); n++; end
    cnt = 0;
    while (err !== 1'b1 && cnt < TMO + 50) begin @(negedge clk); cnt++; end
    total++; if (cnt != TMO) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", cnt, TMO); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL tmo_release got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
    repeat (2) @(negedge clk);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", err_cnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b exp=0", busy); end
  endtask
`else
  task automatic test_retry;
    logic [7:0] rx; logic par, stp; bit to; int d0, e0, p0, n;
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
    send(8'hF4);
    device_xfer(11, 1'b1, rx, par, stp, to);
    device_xfer(11, 1'b1, rx, par, stp, to);
    device_xfer(11, 1'b0, rx, par, stp, to);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (inh_phases - p0 != 3) begin bad++; $display("FAIL retry_phases got=%0d exp=3", inh_phases - p0); end
    total++; if (rx !== 8'hF4) begin bad++; $display("FAIL retry_byte got=%h exp=f4", rx); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL retry_done got=%0d exp=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL retry_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_timeout;
    int n, e0, p0;
    e0 = err_cnt; p0 = inh_phases;
    send(8'h55);
    n = 0;
    while (err_cnt == e0 && n < 3 * (TMO + INH + 20) + 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL tmo_err got=%0d exp=1", err_cnt - e0); end
    total++; if (inh_phases - p0 != 3) begin bad++; $display("FAIL tmo_phases got=%0d exp=3", inh_phases - p0); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL tmo_release got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [7:0] rx; logic par, stp; bit to; int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    device_xfer(5, 1'b0, rx, par, stp, to);
    // bit 4 of 0xED is 0, so the host should be pulling data low here
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", ps2_data_oe); end
    reset = 1'b1;
    #1;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_release got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (done_cnt != d0 || err_cnt != e0) begin bad++; $display("FAIL rst_mid_pulse got=%0d/%0d exp=0/0", done_cnt - d0, err_cnt - e0); end
    d0 = done_cnt;
    send(8'hED);
    device_xfer(11, 1'b0, rx, par, stp, to);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (rx !== 8'hED || par !== 1'b1) begin bad++; $display("FAIL rst_mid_resend got=%h/%b exp=ed/1", rx, par); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rst_mid_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_stb_busy;
    logic [7:0] rx; logic par, stp; bit to; int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5);
    fork
      device_xfer(11, 1'b0, rx, par, stp, to);
      begin
        repeat (INH + 200) @(negedge clk);
        tx_data = 8'h00;
        tx_stb  = 1'b1;
        @(negedge clk);
        tx_stb  = 1'b0;
      end
    join
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++; if (rx !== 8'hA5 || par !== 1'b1) begin bad++; $display("FAIL stb_busy_byte got=%h/%b exp=a5/1", rx, par); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL stb_busy_done got=%0d exp=1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL stb_busy_err got=%0d exp=0", err_cnt - e0); end
    repeat (INH + 20) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stb_busy_idle got=%b exp=0", busy); end
  endtask

  initial begin
    reset    = 1'b1;
    tx_stb   = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (4) @(negedge clk);
    test_reset;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_ack_f4;
`ifndef PS2_HOST_TX_RETRY_EN
    test_nack_ff;
`else
    test_retry;
`endif
    test_timeout;
    test_reset_mid;
    test_stb_busy;
    total++; if (both_cnt != 0) begin bad++; $display("FAIL done_err_overlap got=%0d exp=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
